// File: rtl/apb_slave_if_if.sv
`default_nettype none
// =============================================================================
// apb_slave_if_if : APB completer bus and local backend request signals.
// Optional feature macro: APB_WSTRB_EN (adds apb_strb_in).  Rev 1.0
// =============================================================================
interface apb_slave_if_if #(
   parameter int APB_DATA_WIDTH = 32,
   parameter int APB_ADDR_WIDTH = 32
);
   logic                          apb_psel_in;
   logic                          apb_penable_in;
   logic                          apb_write_in;
   logic [APB_ADDR_WIDTH-1:0]     apb_addr_in;
   logic [APB_DATA_WIDTH-1:0]     apb_wdata_in;
`ifdef APB_WSTRB_EN
   logic [APB_DATA_WIDTH/8-1:0]   apb_strb_in;
`endif
   logic [APB_DATA_WIDTH-1:0]     apb_rdata_out;
   logic                          apb_ready_out;
   logic                          apb_slverr_out;

   logic                          other_sel_out;
   logic                          other_write_out;
   logic [APB_ADDR_WIDTH-1:0]     other_addr_out;
   logic [APB_DATA_WIDTH-1:0]     other_wdata_out;
   logic [APB_DATA_WIDTH/8-1:0]   other_strb_out;
   logic [APB_DATA_WIDTH-1:0]     other_rdata_in;
   logic                          other_ready_in;
   logic                          other_error_in;

   modport slave (
`ifdef APB_WSTRB_EN
      input  apb_strb_in,
`endif
      input  apb_psel_in, apb_penable_in, apb_write_in, apb_addr_in, apb_wdata_in,
      output apb_rdata_out, apb_ready_out, apb_slverr_out,
      output other_sel_out, other_write_out, other_addr_out, other_wdata_out, other_strb_out,
      input  other_rdata_in, other_ready_in, other_error_in
   );

   modport master (
`ifdef APB_WSTRB_EN
      output apb_strb_in,
`endif
      output apb_psel_in, apb_penable_in, apb_write_in, apb_addr_in, apb_wdata_in,
      input  apb_rdata_out, apb_ready_out, apb_slverr_out,
      input  other_sel_out, other_write_out, other_addr_out, other_wdata_out, other_strb_out,
      output other_rdata_in, other_ready_in, other_error_in
   );
endinterface
`default_nettype wire

// File: rtl/apb_slave_if.sv
`default_nettype none
// =============================================================================
// apb_slave_if : APB completer bridging to a single-request local backend.
// Optional feature macro: APB_WSTRB_EN (write strobes from the bus).  Rev 1.0
// =============================================================================
module apb_slave_if #(
   parameter int              APB_DATA_WIDTH = 32,
   parameter int              APB_ADDR_WIDTH = 32,
   parameter int              TIMEOUT_CYCLE  = 6,
   parameter longint unsigned ADDR_BASE      = 0,
   parameter longint unsigned ADDR_SIZE      = 'h1000
) (
   input  wire logic     apb_clk_in,
   input  wire logic     apb_rstn_in,
   output logic          other_clk_out,
   apb_slave_if_if.slave bus
);
   localparam int SW = APB_DATA_WIDTH / 8;
   localparam int CW = $clog2(TIMEOUT_CYCLE + 1);
   localparam logic [CW-1:0]             LAST_WAIT = CW'(TIMEOUT_CYCLE - 1);
   localparam logic [APB_ADDR_WIDTH-1:0] BASE      = ADDR_BASE[APB_ADDR_WIDTH-1:0];
   localparam logic [APB_ADDR_WIDTH:0]   WIN_SIZE  = ADDR_SIZE[APB_ADDR_WIDTH:0];

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

   state_t                    state, state_nxt;
   logic [CW-1:0]             wait_cnt, wait_cnt_nxt;
   logic [APB_DATA_WIDTH-1:0] rdata, rdata_nxt;
   logic                      ready, ready_nxt;
   logic                      slverr, slverr_nxt;
   logic                      sel, sel_nxt;
   logic                      wr, wr_nxt;
   logic [APB_ADDR_WIDTH-1:0] addr, addr_nxt;
   logic [APB_DATA_WIDTH-1:0] wdata, wdata_nxt;
   logic [SW-1:0]             strb, strb_nxt;

   logic [APB_ADDR_WIDTH-1:0] offset;
   logic                      in_range;
   logic [SW-1:0]             req_strb;
   logic                      strb_err;

   assign other_clk_out = apb_clk_in;

   // Offset compare avoids overflow of BASE+SIZE at the top of the address space.
   assign offset   = bus.apb_addr_in - BASE;
   assign in_range = (bus.apb_addr_in >= BASE) && ({1'b0, offset} < WIN_SIZE);

`ifdef APB_WSTRB_EN
   assign req_strb = bus.apb_strb_in;
   assign strb_err = !bus.apb_write_in && (bus.apb_strb_in != '0);
`else
   assign req_strb = {SW{bus.apb_write_in}};
   assign strb_err = 1'b0;
`endif

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      rdata_nxt    = rdata;
      ready_nxt    = ready;
      slverr_nxt   = slverr;
      sel_nxt      = sel;
      wr_nxt       = wr;
      addr_nxt     = addr;
      wdata_nxt    = wdata;
      strb_nxt     = strb;
      case (state)
         IDLE: begin
            if (bus.apb_psel_in && !bus.apb_penable_in) begin
               if (in_range && !strb_err) begin
                  state_nxt    = BUSY;
                  sel_nxt      = 1'b1;
                  wr_nxt       = bus.apb_write_in;
                  addr_nxt     = offset;
                  wdata_nxt    = bus.apb_wdata_in;
                  strb_nxt     = req_strb;
                  wait_cnt_nxt = '0;
               end else begin
                  state_nxt  = RESP;
                  ready_nxt  = 1'b1;
                  slverr_nxt = 1'b1;
                  rdata_nxt  = '0;
               end
            end
         end
         BUSY: begin
            if (!bus.apb_psel_in) begin
               state_nxt  = IDLE;
               sel_nxt    = 1'b0;
               ready_nxt  = 1'b0;
               slverr_nxt = 1'b0;
            end else if (bus.other_ready_in) begin
               state_nxt  = RESP;
               sel_nxt    = 1'b0;
               ready_nxt  = 1'b1;
               slverr_nxt = bus.other_error_in;
               rdata_nxt  = wr ? '0 : bus.other_rdata_in;
            end else if (wait_cnt == LAST_WAIT) begin
               state_nxt  = RESP;
               sel_nxt    = 1'b0;
               ready_nxt  = 1'b1;
               slverr_nxt = 1'b1;
               rdata_nxt  = '0;
            end else begin
               wait_cnt_nxt = wait_cnt + CW'(1);
            end
         end
         RESP: begin
            // Either completion or abort: PREADY is a single-cycle pulse in both cases.
            state_nxt  = IDLE;
            ready_nxt  = 1'b0;
            slverr_nxt = 1'b0;
         end
         default: begin
            state_nxt  = IDLE;
            sel_nxt    = 1'b0;
            ready_nxt  = 1'b0;
            slverr_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         state    <= IDLE;
         wait_cnt <= '0;
         rdata    <= '0;
         ready    <= 1'b0;
         slverr   <= 1'b0;
         sel      <= 1'b0;
         wr       <= 1'b0;
         addr     <= '0;
         wdata    <= '0;
         strb     <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         rdata    <= rdata_nxt;
         ready    <= ready_nxt;
         slverr   <= slverr_nxt;
         sel      <= sel_nxt;
         wr       <= wr_nxt;
         addr     <= addr_nxt;
         wdata    <= wdata_nxt;
         strb     <= strb_nxt;
      end
   end

   assign bus.apb_rdata_out   = rdata;
   assign bus.apb_ready_out   = ready;
   assign bus.apb_slverr_out  = slverr;
   assign bus.other_sel_out   = sel;
   assign bus.other_write_out = wr;
   assign bus.other_addr_out  = addr;
   assign bus.other_wdata_out = wdata;
   assign bus.other_strb_out  = strb;
endmodule
`default_nettype wire
